// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: accepts one 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, then holds the result until taken.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy,
  output logic [1:0]   dbg_state_o
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // With four columns per cycle the step wraps to 0 and the counter stays at 0.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d;
  logic         mode_q, mode_d;
  logic [127:0] out_q, out_d;
  logic [1:0]   idx;
  logic [6:0]   base;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0]  a [4];
    logic [7:0]  m2 [4];
    logic [7:0]  m3 [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [7:0]  m4;
    logic [7:0]  m8;
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xtime(a[i]);
      m4    = xtime(m2[i]);
      m8    = xtime(m4);
      m3[i] = m2[i] ^ a[i];
      m9[i] = m8 ^ a[i];
      mb[i] = m8 ^ m2[i] ^ a[i];
      md[i] = m8 ^ m4 ^ a[i];
      me[i] = m8 ^ m4 ^ m2[i];
    end
    // Row r uses the circulant coefficients rotated right by r.
    for (int r = 0; r < 4; r++) begin
      if (inv)
        res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
      else
        res[31-8*r -: 8] = m2[r] ^ m3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return res;
  endfunction

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    mode_d  = mode_q;
    out_d   = out_q;
    idx     = '0;
    base    = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          mode_d  = mode;
          col_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          idx  = col_q + 2'(g);
          base = {~idx, 5'b11111};
          work_d[base -: 32] = mix_col(work_q[base -: 32], mode_q);
        end
        col_d = col_q + COL_STEP;
        // Result register is loaded only here, so partial RUN values never show.
        if (col_q == LAST_COL) begin
          out_d   = work_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      work_q  <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign state_out   = out_q;
  assign dbg_state_o = state_q;

endmodule
